matrices_stream_driver: RTL and testbench
=========================================

MATRICES_STREAM_DRIVER -- requirements
Module: matrices_stream_driver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, element and bus width.
REQ-002 SHALL have parameter MAX_ELEMS, default 64 (power of 2), operand bank depth per matrix.
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum cycles waited for a result.
REQ-004 SHALL have local parameter AW = log2(MAX_ELEMS), the address width.
REQ-005 i_clk  in  1  sole clock; all logic on rising edge.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_wr_en  in  1  operand write strobe.
REQ-008 i_wr_bank  in  1  0 = bank A, 1 = bank B.
REQ-009 i_wr_addr  in  AW  element index.
REQ-010 i_wr_data  in  DATA_WIDTH  operand value.
REQ-011 i_start  in  1  single-cycle job start pulse.
REQ-012 i_count  in  AW+1  elements per matrix (N).
REQ-013 o_busy  out  1  job in progress.
REQ-014 o_done  out  1  one-cycle pulse when a job completes.
REQ-015 o_error  out  1  one-cycle pulse when a job is rejected or aborted.
REQ-016 o_push  out  1  push strobe to the sum unit.
REQ-017 o_pop  out  1  pop strobe to the sum unit.
REQ-018 o_data  out  DATA_WIDTH  data to the sum unit.
REQ-019 i_unit_data  in  DATA_WIDTH  result data from the sum unit.
REQ-020 i_unit_ready  in  1  unit ready flag.
REQ-021 i_unit_res_avail  in  1  unit result-available flag.
REQ-022 o_res_valid  out  1  result strobe.
REQ-023 o_res_index  out  AW  result element index.
REQ-024 o_res_data  out  DATA_WIDTH  result value.

Function
REQ-025 States SHALL be IDLE, HDR, CNT, SEND_A, SEND_B, WAIT_RES, POP, DONE.
REQ-026 Writes SHALL be accepted only in IDLE; writes while o_busy=1 SHALL be ignored.
REQ-027 i_start in IDLE with 1<=i_count<=MAX_ELEMS SHALL latch N and move to HDR; otherwise o_error SHALL pulse and the block SHALL stay in IDLE.
REQ-028 i_start while o_busy=1 SHALL be ignored.
REQ-029 o_push SHALL be 1 for exactly 2+2N consecutive cycles (HDR, CNT, SEND_A x N, SEND_B x N) and 0 otherwise.
REQ-030 Push data order SHALL be: in HDR, o_data=0; in CNT, o_data=N; then A[0..N-1]; then B[0..N-1]. o_data SHALL be registered, with bank reads prefetched one cycle ahead and no bubbles.
REQ-031 After SEND_B the block SHALL enter WAIT_RES and load the timeout counter with TIMEOUT.
REQ-032 WAIT_RES SHALL move to POP on i_unit_res_avail=1 or i_unit_ready=1.
REQ-033 If the timeout counter reaches 0 in WAIT_RES, o_error SHALL pulse and the block SHALL return to IDLE.
REQ-034 In POP, o_pop SHALL be 1. i_unit_data SHALL be sampled on each edge starting one cycle after o_pop rises, while i_unit_res_avail=1.
REQ-035 Results SHALL arrive last element first: the k-th capture (k=0..N-1) SHALL drive o_res_valid=1, o_res_index=N-1-k and o_res_data=captured value, registered with one-cycle latency.
REQ-036 After N captures, o_pop SHALL drop and the block SHALL enter DONE; DONE SHALL pulse o_done for 1 cycle and then return to IDLE.
REQ-037 If i_unit_res_avail falls before N captures, o_error SHALL pulse, o_pop SHALL drop, and the block SHALL return to IDLE.
REQ-038 o_busy SHALL be 1 in every state except IDLE.
REQ-039 The data path SHALL only pass data through; no arithmetic is performed, and widths SHALL be DATA_WIDTH throughout.

Reset
REQ-040 i_rst=1 SHALL force IDLE and clear all outputs to 0 (o_data=0, o_res_index=0) on the next edge, including mid-job.
REQ-041 Bank contents SHALL NOT be cleared by reset.

Structure
REQ-042 A shared package SHALL hold the state enumeration and the default values of DATA_WIDTH, MAX_ELEMS and TIMEOUT.
REQ-043 One sub-module, matrices_operand_bank, SHALL implement each bank as a single-write, single-read RAM with 1-cycle read latency, instantiated twice.

Verification
REQ-044 Load A=B={0,1,3,3,1,2}, start with N=6 -> o_push high for 14 cycles; o_data = 0, 6, 0,1,3,3,1,2, 0,1,3,3,1,2.
REQ-045 Same job; the unit model returns sums {0,2,6,6,2,4} in reverse -> indices 5..0 with data 4,2,6,6,2,0; then a single o_done pulse.
REQ-046 i_count=0 and i_count=MAX_ELEMS+1 -> o_error pulse, o_push stays 0, o_busy stays 0.
REQ-047 Unit never raises i_unit_res_avail or i_unit_ready -> o_error exactly TIMEOUT cycles after WAIT_RES is entered; block back in IDLE.
REQ-048 i_unit_res_avail drops after 3 of 6 captures -> o_error pulse, no o_done, o_pop=0.
REQ-049 i_rst asserted during SEND_A -> all outputs 0 next cycle; a new N=1 job with A={7}, B={9} then runs correctly.

Source files
------------

// File: rtl/matrices_stream_driver_pkg.sv
// Shared definitions for the matrices stream driver.
// Holds the default parameter values and the controller state enumeration
// used by the top level and the operand bank.
package matrices_stream_driver_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_MAX_ELEMS  = 64;
  localparam int unsigned DEF_TIMEOUT    = 1024;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CNT,
    SEND_A,
    SEND_B,
    WAIT_RES,
    POP,
    DONE
  } state_e;

endpackage

// File: rtl/matrices_operand_bank.sv
// Operand bank: single-write, single-read RAM with one-cycle read latency.
// Contents are never reset.
//   clk      : clock, rising edge
//   wr_en    : write strobe
//   wr_addr  : write element index
//   wr_data  : write value
//   rd_addr  : read element index (sampled every cycle)
//   rd_data  : registered read value, valid the cycle after rd_addr
module matrices_operand_bank
  import matrices_stream_driver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_MAX_ELEMS,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage write and registered read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/matrices_stream_driver.sv
// Matrices stream driver: loads two operand matrices (banks A and B), streams
// a job to an external sum unit as {0, N, A[0..N-1], B[0..N-1]}, then pops the
// N results back (last element first) and presents them with their indices.
//   i_clk, i_rst      : clock and synchronous active-high reset
//   i_wr_*            : operand write port, honoured only while idle
//   i_start, i_count  : job start pulse and element count N
//   o_busy/o_done/o_error : job status (done/error are one-cycle pulses)
//   o_push, o_pop, o_data : strobes and data toward the sum unit
//   i_unit_*          : result data and status flags from the sum unit
//   o_res_*           : result strobe, element index and value
module matrices_stream_driver
  import matrices_stream_driver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_ELEMS  = DEF_MAX_ELEMS,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  localparam int unsigned AW        = $clog2(MAX_ELEMS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic                  i_wr_bank,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_start,
  input  logic [AW:0]           i_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic                  o_push,
  output logic                  o_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic [DATA_WIDTH-1:0] i_unit_data,
  input  logic                  i_unit_ready,
  input  logic                  i_unit_res_avail,
  output logic                  o_res_valid,
  output logic [AW-1:0]         o_res_index,
  output logic [DATA_WIDTH-1:0] o_res_data
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  // Stream sequence counter covers 2N+2 cycles without ambiguity
  localparam int unsigned SW = AW + 2;

  state_e                state_q, state_d;
  logic [AW:0]           n_q, n_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [SW-1:0]         seq_q, seq_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  rd_sel_b_q;

  logic                  busy_d, done_d, err_d, push_d, pop_d, res_valid_d;
  logic [DATA_WIDTH-1:0] data_d, res_data_d;
  logic [AW-1:0]         res_index_d;

  logic                  wr_ok, a_we, b_we;
  logic [DATA_WIDTH-1:0] a_rd, b_rd;
  logic [AW-1:0]         last_idx;
  logic [SW-1:0]         n_ext;
  logic                  rd_bank;
  logic [AW-1:0]         rd_addr;
  logic                  count_ok;

  // Operand writes only land while idle
  assign wr_ok = i_wr_en && (state_q == IDLE);
  assign a_we  = wr_ok && !i_wr_bank;
  assign b_we  = wr_ok &&  i_wr_bank;

  assign last_idx = AW'(n_q - (AW+1)'(1));
  assign n_ext    = SW'(n_q);

  // Read element seq_q of the A-then-B sequence; two cycles ahead of o_data
  assign rd_bank = (seq_q >= n_ext);
  assign rd_addr = rd_bank ? AW'(seq_q - n_ext) : AW'(seq_q);

  assign count_ok = (i_count != '0) && (i_count <= (AW+1)'(MAX_ELEMS));

  matrices_operand_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_ELEMS)
  ) u_bank_a (
    .clk     (i_clk),
    .wr_en   (a_we),
    .wr_addr (i_wr_addr),
    .wr_data (i_wr_data),
    .rd_addr (rd_addr),
    .rd_data (a_rd)
  );

  matrices_operand_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_ELEMS)
  ) u_bank_b (
    .clk     (i_clk),
    .wr_en   (b_we),
    .wr_addr (i_wr_addr),
    .wr_data (i_wr_data),
    .rd_addr (rd_addr),
    .rd_data (b_rd)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    idx_d       = idx_q;
    seq_d       = '0;
    tmo_d       = tmo_q;
    err_d       = 1'b0;
    res_valid_d = 1'b0;
    res_index_d = '0;
    res_data_d  = '0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (count_ok) begin
            n_d     = i_count;
            idx_d   = '0;
            state_d = HDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      HDR: begin
        seq_d   = seq_q + SW'(1);
        state_d = CNT;
      end

      CNT: begin
        seq_d   = seq_q + SW'(1);
        idx_d   = '0;
        state_d = SEND_A;
      end

      SEND_A: begin
        seq_d = seq_q + SW'(1);
        if (idx_q == last_idx) begin
          idx_d   = '0;
          state_d = SEND_B;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end

      SEND_B: begin
        seq_d = seq_q + SW'(1);
        if (idx_q == last_idx) begin
          idx_d   = '0;
          tmo_d   = TW'(TIMEOUT);
          state_d = WAIT_RES;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end

      WAIT_RES: begin
        if (i_unit_res_avail || i_unit_ready) begin
          idx_d   = '0;
          state_d = POP;
        end else if (tmo_q <= TW'(1)) begin
          // Counter hits zero on this edge
          tmo_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end

      POP: begin
        if (i_unit_res_avail) begin
          res_valid_d = 1'b1;
          res_index_d = last_idx - idx_q;
          res_data_d  = i_unit_data;
          if (idx_q == last_idx) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status and strobe outputs track the state being entered
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    pop_d  = (state_d == POP);
    push_d = (state_d == HDR) || (state_d == CNT) ||
             (state_d == SEND_A) || (state_d == SEND_B);

    case (state_d)
      CNT:            data_d = DATA_WIDTH'(n_d);
      SEND_A, SEND_B: data_d = rd_sel_b_q ? b_rd : a_rd;
      default:        data_d = '0;
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      seq_q       <= '0;
      tmo_q       <= '0;
      rd_sel_b_q  <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
      o_push      <= 1'b0;
      o_pop       <= 1'b0;
      o_data      <= '0;
      o_res_valid <= 1'b0;
      o_res_index <= '0;
      o_res_data  <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      seq_q       <= seq_d;
      tmo_q       <= tmo_d;
      rd_sel_b_q  <= rd_bank;
      o_busy      <= busy_d;
      o_done      <= done_d;
      o_error     <= err_d;
      o_push      <= push_d;
      o_pop       <= pop_d;
      o_data      <= data_d;
      o_res_valid <= res_valid_d;
      o_res_index <= res_index_d;
      o_res_data  <= res_data_d;
    end
  end

endmodule

// File: tb/tb_matrices_stream_driver.sv
// Testbench for matrices_stream_driver: table-driven jobs with random operands,
// a bench-side sum unit, and hand sequences for rejection and mid-job reset.
module tb_matrices_stream_driver;

  localparam int unsigned DW = 16;
  localparam int unsigned ME = 8;
  localparam int unsigned TO = 20;
  localparam int unsigned AW = $clog2(ME);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          wr_bank = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic [AW:0]   count = '0;
  logic          busy, done, error, push, pop, res_valid;
  logic [DW-1:0] data, res_data;
  logic [AW-1:0] res_index;
  logic [DW-1:0] unit_data = '0;
  logic          unit_ready = 1'b0;
  logic          unit_avail = 1'b0;

  always #5 clk = ~clk;

  matrices_stream_driver #(
    .DATA_WIDTH (DW),
    .MAX_ELEMS  (ME),
    .TIMEOUT    (TO)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_wr_en          (wr_en),
    .i_wr_bank        (wr_bank),
    .i_wr_addr        (wr_addr),
    .i_wr_data        (wr_data),
    .i_start          (start),
    .i_count          (count),
    .o_busy           (busy),
    .o_done           (done),
    .o_error          (error),
    .o_push           (push),
    .o_pop            (pop),
    .o_data           (data),
    .i_unit_data      (unit_data),
    .i_unit_ready     (unit_ready),
    .i_unit_res_avail (unit_avail),
    .o_res_valid      (res_valid),
    .o_res_index      (res_index),
    .o_res_data       (res_data)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Inputs are driven and outputs read 1 time unit after the falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Observer: logs everything the DUT emits, once per cycle
  int            cyc = 0;
  bit            prev_push = 1'b0;
  int            push_runs = 0;
  int            push_fall_cyc = -1;
  int            done_n = 0;
  logic [DW-1:0] push_log [$];
  int            err_log  [$];
  logic [AW-1:0] ridx_log [$];
  logic [DW-1:0] rdat_log [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (push) push_log.push_back(data);
    if (push && !prev_push) push_runs++;
    if (!push && prev_push) push_fall_cyc = cyc;
    prev_push = push;
    if (error) err_log.push_back(cyc);
    if (done) done_n++;
    if (res_valid) begin
      ridx_log.push_back(res_index);
      rdat_log.push_back(res_data);
    end
  end

  task automatic clear_logs();
    push_log.delete();
    err_log.delete();
    ridx_log.delete();
    rdat_log.delete();
    push_runs     = 0;
    push_fall_cyc = -1;
    done_n        = 0;
  endtask

  // Operand data for the current job
  logic [DW-1:0] ja [ME];
  logic [DW-1:0] jb [ME];

  task automatic load_banks(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_bank = 1'b0; wr_addr = AW'(i); wr_data = ja[i];
      tick();
    end
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_bank = 1'b1; wr_addr = AW'(i); wr_data = jb[i];
      tick();
    end
    wr_en = 1'b0;
  endtask

  // mode 0: unit answers; 1: unit silent; 2: unit drops avail after `drop`
  typedef struct {
    int n;
    int mode;
    int drop;
    int exp_done;
    int exp_err;
    int exp_res;
  } job_t;

  task automatic run_job(input job_t jd);
    logic [DW-1:0] exp_stream [$];
    logic [DW-1:0] sums [ME];
    int t;
    int n;
    int lim;
    n = jd.n;
    for (int i = 0; i < n; i++) sums[i] = ja[i] + jb[i];
    exp_stream.push_back('0);
    exp_stream.push_back(DW'(n));
    for (int i = 0; i < n; i++) exp_stream.push_back(ja[i]);
    for (int i = 0; i < n; i++) exp_stream.push_back(jb[i]);

    load_banks(n);
    clear_logs();
    start = 1'b1; count = (AW+1)'(n);
    tick();
    // While busy, hammer the write and start inputs; all must be ignored
    t = 0;
    while (!(push_runs > 0 && !push) && t < 4 * ME + 10) begin
      start   = 1'b1;
      count   = (AW+1)'($urandom);
      wr_en   = 1'b1;
      wr_bank = 1'($urandom);
      wr_addr = AW'($urandom);
      wr_data = DW'($urandom);
      tick();
      t++;
    end
    start = 1'b0; wr_en = 1'b0;
    check($sformatf("n%0d push_len", n), push_log.size(), 2 + 2 * n);
    check($sformatf("n%0d push_runs", n), push_runs, 1);
    for (int i = 0; i < push_log.size() && i < exp_stream.size(); i++)
      check($sformatf("n%0d push[%0d]", n, i), int'(push_log[i]), int'(exp_stream[i]));

    if (jd.mode != 1) begin
      repeat ($urandom_range(0, 4)) tick();
      unit_ready = 1'b1;
      t = 0;
      while (!pop && t < 10) begin tick(); t++; end
      check($sformatf("n%0d pop_rise", n), int'(pop), 1);
      unit_ready = 1'b0;
      lim = (jd.mode == 2) ? jd.drop : n;
      for (int k = 0; k < lim; k++) begin
        unit_data  = sums[n - 1 - k];
        unit_avail = 1'b1;
        tick();
      end
      unit_avail = 1'b0;
      unit_data  = DW'($urandom);
    end

    t = 0;
    while (busy && t < int'(TO) + 4 * int'(ME) + 20) begin tick(); t++; end
    tick(); tick();

    check($sformatf("n%0d done_cnt", n), done_n, jd.exp_done);
    check($sformatf("n%0d err_cnt", n), err_log.size(), jd.exp_err);
    if (jd.mode == 1 && err_log.size() > 0)
      check($sformatf("n%0d timeout_cycles", n), err_log[0] - push_fall_cyc, int'(TO));
    check($sformatf("n%0d res_cnt", n), rdat_log.size(), jd.exp_res);
    for (int k = 0; k < rdat_log.size() && k < jd.exp_res; k++) begin
      check($sformatf("n%0d res_idx[%0d]", n, k), int'(ridx_log[k]), n - 1 - k);
      check($sformatf("n%0d res_dat[%0d]", n, k), int'(rdat_log[k]), int'(sums[n - 1 - k]));
    end
    check($sformatf("n%0d pop_end", n), int'(pop), 0);
    check($sformatf("n%0d busy_end", n), int'(busy), 0);
  endtask

  typedef struct {
    logic [AW:0] cnt;
  } rej_t;

  job_t jobs [8];
  rej_t rejs [3];
  int   spec_ab  [6] = '{0, 1, 3, 3, 1, 2};
  int   spec_res [6] = '{4, 2, 6, 6, 2, 0};
  int   t;

  initial begin
    jobs[0] = '{6,  0, 0, 1, 0, 6};
    jobs[1] = '{1,  0, 0, 1, 0, 1};
    jobs[2] = '{ME, 0, 0, 1, 0, ME};
    jobs[3] = '{3,  0, 0, 1, 0, 3};
    jobs[4] = '{5,  1, 0, 0, 1, 0};
    jobs[5] = '{6,  2, 3, 0, 1, 3};
    jobs[6] = '{4,  2, 0, 0, 1, 0};
    jobs[7] = '{7,  0, 0, 1, 0, 7};
    rejs[0] = '{cnt: '0};
    rejs[1] = '{cnt: (AW+1)'(ME + 1)};
    rejs[2] = '{cnt: '1};

    // Reset state
    repeat (3) tick();
    check("rst busy", int'(busy), 0);
    check("rst push", int'(push), 0);
    check("rst pop", int'(pop), 0);
    check("rst error", int'(error), 0);
    check("rst done", int'(done), 0);
    check("rst data", int'(data), 0);
    check("rst res_valid", int'(res_valid), 0);
    rst = 1'b0;
    tick();

    // Out-of-range counts are rejected with a single error pulse
    for (int r = 0; r < 3; r++) begin
      clear_logs();
      start = 1'b1; count = rejs[r].cnt;
      tick();
      start = 1'b0;
      check($sformatf("rej%0d error", r), int'(error), 1);
      check($sformatf("rej%0d busy", r), int'(busy), 0);
      check($sformatf("rej%0d push", r), int'(push), 0);
      tick();
      check($sformatf("rej%0d error_pulse", r), int'(error), 0);
      check($sformatf("rej%0d busy_after", r), int'(busy), 0);
      check($sformatf("rej%0d no_push", r), push_runs, 0);
    end

    // Table of jobs; row 0 uses the fixed A=B example
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < int'(ME); i++) begin
        ja[i] = (j == 0 && i < 6) ? DW'(spec_ab[i]) : DW'($urandom);
        jb[i] = (j == 0 && i < 6) ? DW'(spec_ab[i]) : DW'($urandom);
      end
      run_job(jobs[j]);
      if (j == 0) begin
        for (int k = 0; k < 6 && k < rdat_log.size(); k++)
          check($sformatf("example res[%0d]", k), int'(rdat_log[k]), spec_res[k]);
        check("example push1", push_log.size() > 1 ? int'(push_log[1]) : -1, 6);
      end
    end

    // Reset in the middle of SEND_A, then a fresh N=1 job
    for (int i = 0; i < 4; i++) begin
      ja[i] = DW'($urandom) | DW'(1);
      jb[i] = DW'($urandom);
    end
    load_banks(4);
    clear_logs();
    start = 1'b1; count = (AW+1)'(4);
    tick();
    start = 1'b0;
    t = 0;
    while (push_log.size() < 3 && t < 20) begin tick(); t++; end
    check("midrst in_send_a", int'(data), int'(ja[0]));
    rst = 1'b1;
    tick();
    check("midrst busy", int'(busy), 0);
    check("midrst push", int'(push), 0);
    check("midrst data", int'(data), 0);
    check("midrst pop", int'(pop), 0);
    check("midrst res_index", int'(res_index), 0);
    check("midrst error", int'(error), 0);
    rst = 1'b0;
    tick();
    ja[0] = DW'(7);
    jb[0] = DW'(9);
    run_job('{1, 0, 0, 1, 0, 1});
    check("n1 stream A", push_log.size() > 2 ? int'(push_log[2]) : -1, 7);
    check("n1 stream B", push_log.size() > 3 ? int'(push_log[3]) : -1, 9);
    check("n1 result", rdat_log.size() > 0 ? int'(rdat_log[0]) : -1, 16);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
    $fatal(1);
  end

endmodule
